// File: rtl/spart_bus_arbiter.sv
// spart_bus_arbiter
// Two-requester round-robin front end for the SPART processor-side bus.
// Each granted transaction waits for SPART readiness (tbr for writes,
// rda for RX reads), issues exactly one bus cycle, then acks its requester.
// A transaction that never becomes ready is acked with err after
// TIMEOUT_CYCLES cycles of waiting and never reaches the bus.
module spart_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  req_rw,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    input  logic        rda,
    input  logic        tbr
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RDY = 2'd1;
    localparam logic [1:0] ST_ISSUE    = 2'd2;
    localparam logic [1:0] ST_ACK      = 2'd3;

    // Last counter value at which a not-ready transaction is abandoned.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_reg,      state_next;
    logic        last_grant_reg, last_grant_next;
    logic        gnt_reg,        gnt_next;
    logic        gnt_rw_reg,     gnt_rw_next;
    logic [1:0]  gnt_addr_reg,   gnt_addr_next;
    logic [7:0]  gnt_wdata_reg,  gnt_wdata_next;
    logic [15:0] cnt_reg,        cnt_next;
    logic        err_reg,        err_next;
    logic [7:0]  rdata_reg,      rdata_next;

    logic [1:0]  req_addr_arr  [2];
    logic [7:0]  req_wdata_arr [2];
    logic        winner;
    logic        ready;

    // Per-requester views of the packed request buses and the one-hot ack.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            localparam logic IDX = (gi == 1);
            assign req_addr_arr[gi]  = req_addr[2*gi +: 2];
            assign req_wdata_arr[gi] = req_wdata[8*gi +: 8];
            assign ack[gi]           = (state_reg == ST_ACK) && (gnt_reg == IDX);
        end
    endgenerate

    // Round-robin pick: a lone request wins outright, a tie goes to the
    // requester that was not granted last time.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_grant_reg;
        end
    end

    // SPART readiness for the latched transaction. Writes to 01 and status
    // reads never stall; reads of the DB registers (10/11) are treated as
    // always ready since they involve no FIFO handshake.
    always_comb begin
        ready = 1'b1;
        if (!gnt_rw_reg) begin
            ready = (gnt_addr_reg == 2'b01) ? 1'b1 : tbr;
        end else if (gnt_addr_reg == 2'b00) begin
            ready = rda;
        end
    end

    // Next-state and datapath update for the grant / wait / issue / ack sequence.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        gnt_next        = gnt_reg;
        gnt_rw_next     = gnt_rw_reg;
        gnt_addr_next   = gnt_addr_reg;
        gnt_wdata_next  = gnt_wdata_reg;
        cnt_next        = cnt_reg;
        err_next        = err_reg;
        rdata_next      = rdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    gnt_next        = winner;
                    last_grant_next = winner;
                    gnt_rw_next     = req_rw[winner];
                    gnt_addr_next   = req_addr_arr[winner];
                    gnt_wdata_next  = req_wdata_arr[winner];
                    cnt_next        = '0;
                    err_next        = 1'b0;
                    state_next      = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                // Readiness is checked first so a late ready still issues.
                if (ready) begin
                    state_next = ST_ISSUE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_ISSUE: begin
                if (gnt_rw_reg) begin
                    rdata_next = databus;
                end
                state_next = ST_ACK;
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            gnt_reg        <= 1'b0;
            gnt_rw_reg     <= 1'b1;
            gnt_addr_reg   <= 2'b00;
            gnt_wdata_reg  <= 8'h00;
            cnt_reg        <= 16'd0;
            err_reg        <= 1'b0;
            rdata_reg      <= 8'h00;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            gnt_reg        <= gnt_next;
            gnt_rw_reg     <= gnt_rw_next;
            gnt_addr_reg   <= gnt_addr_next;
            gnt_wdata_reg  <= gnt_wdata_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
            rdata_reg      <= rdata_next;
        end
    end

    // Bus outputs exist only during ISSUE; otherwise iorw=1 keeps the bus undriven.
    assign iocs    = (state_reg == ST_ISSUE);
    assign iorw    = iocs ? gnt_rw_reg : 1'b1;
    assign ioaddr  = iocs ? gnt_addr_reg : 2'b00;
    assign databus = (iocs && !gnt_rw_reg) ? gnt_wdata_reg : 8'hzz;

    assign err   = (state_reg == ST_ACK) && err_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// tb_spart_bus_arbiter
// Directed scenarios with hand-computed expectations, then randomized
// requesters and SPART readiness checked every cycle against a
// transaction-level model of the arbiter.
module tb_spart_bus_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_rw;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  ack;
    logic        err;
    logic [7:0]  rdata;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic        rda;
    logic        tbr;
    logic [7:0]  tb_bus_val;

    // The SPART side answers read cycles only.
    assign databus = (iocs && iorw) ? tb_bus_val : 8'hzz;

    spart_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .rda       (rda),
        .tbr       (tbr)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_miscmp = 0;

    // Transaction-level model: the transaction in service and what the
    // current cycle is doing with it.
    bit         m_busy, m_issue, m_ack, m_err, m_who, m_last, m_rw;
    logic [1:0] m_addr;
    logic [7:0] m_wdata, m_rdata;
    int         m_waited;
    logic [1:0] m_ack_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit spart_ready(bit rw, logic [1:0] addr, logic rda_v, logic tbr_v);
        if (rw) return (addr == 2'b00) ? rda_v : 1'b1;
        return (addr == 2'b01) ? 1'b1 : tbr_v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_issue = 0; m_ack = 0; m_err = 0; m_who = 0; m_last = 1;
        m_rw = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_waited = 0;
    endtask

    task automatic model_step();
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_ack) begin
            m_ack  = 0;
            m_busy = 0;
        end else if (m_issue) begin
            m_issue = 0;
            if (m_rw) m_rdata = tb_bus_val;
            m_err = 0;
            m_ack = 1;
        end else if (m_busy) begin
            if (spart_ready(m_rw, m_addr, rda, tbr)) m_issue = 1;
            else if (m_waited == T - 1) begin
                m_err = 1;
                m_ack = 1;
            end else m_waited++;
        end else if (req != 2'b00) begin
            m_who    = (req == 2'b11) ? !m_last : req[1];
            m_last   = m_who;
            w        = int'(m_who);
            m_rw     = req_rw[w];
            m_addr   = req_addr[2*w +: 2];
            m_wdata  = req_wdata[8*w +: 8];
            m_waited = 0;
            m_busy   = 1;
        end
    endtask

    // One clock: advance the model at the edge, then leave inputs free to change.
    task automatic cycle();
        m_ack_prev = m_ack ? (m_who ? 2'b10 : 2'b01) : 2'b00;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        req   = 2'b00;
        rda   = 1'b0;
        tbr   = 1'b0;
        model_reset();
        #1;
        chk("rst_iocs", iocs, 1'b0);
        chk("rst_iorw", iorw, 1'b1);
        chk("rst_ack", ack, 2'b00);
        repeat (hold) cycle();
        rst_n = 1'b1;
    endtask

    // Runs one transaction already requested; raises rda/tbr after cycle rise_at.
    task automatic run_txn(input int rise_at, output int n_issue, output int n_ack,
                           output logic [7:0] bus_iss, output logic [1:0] ack_got,
                           output logic err_got, output logic [7:0] rdata_got);
        n_issue = -1; n_ack = -1; bus_iss = 0; ack_got = 0; err_got = 0; rdata_got = 0;
        for (int n = 1; n <= 40; n++) begin
            cycle();
            if (n == rise_at) begin
                rda = 1'b1;
                tbr = 1'b1;
            end
            @(negedge clk);
            if (iocs && n_issue < 0) begin
                n_issue = n;
                bus_iss = databus;
            end
            if (ack != 2'b00) begin
                n_ack = n; ack_got = ack; err_got = err; rdata_got = rdata;
                break;
            end
        end
        chk("txn_completed", n_ack > 0, 1'b1);
        cycle();
        req = 2'b00;
    endtask

    task automatic wait_ack(output logic [1:0] a);
        a = 2'b00;
        for (int n = 0; n < 40; n++) begin
            cycle();
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack;
                break;
            end
        end
    endtask

    task automatic rand_attr(input int i);
        logic rw;
        rw = 1'($urandom_range(0, 1));
        req_rw[i] = rw;
        req_addr[2*i +: 2] = rw ? {1'b0, 1'($urandom_range(0, 1))} : 2'($urandom_range(0, 3));
        req_wdata[8*i +: 8] = 8'($urandom);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    logic       prev_iocs = 1'b0;
    logic [1:0] e_ack;
    always @(negedge clk) begin
        e_ack = m_ack ? (m_who ? 2'b10 : 2'b01) : 2'b00;
        chk("iocs", iocs, m_issue);
        chk("iorw", iorw, m_issue ? m_rw : 1'b1);
        chk("ioaddr", ioaddr, m_issue ? m_addr : 2'b00);
        chk("ack", ack, e_ack);
        chk("err", err, m_ack & m_err);
        chk("rdata", rdata, m_rdata);
        chk("iocs_b2b", iocs & prev_iocs, 1'b0);
        if (m_issue && !m_rw) chk("databus", databus, m_wdata);
        if (m_ack)
            $display("txn: req%0d %s addr=%0d wdata=%h err=%0d rdata=%h",
                     m_who, m_rw ? "rd" : "wr", m_addr, m_wdata, m_err, m_rdata);
        prev_iocs <= iocs;
    end

    initial begin
        int ni, na;
        logic [7:0] b, r;
        logic [1:0] a, a0, a1, a2;
        logic e;

        rst_n = 1'b1; req = 0; req_rw = 0; req_addr = 0; req_wdata = 0;
        rda = 0; tbr = 0; tb_bus_val = 8'h00;
        #2;
        do_reset(3);

        // Single write: bus cycle in cycle 2, ack in cycle 3, 4 cycles total.
        tbr = 1; req_rw = 2'b00; req_addr = 4'b0000; req_wdata = 16'h0041; req = 2'b01;
        run_txn(-1, ni, na, b, a, e, r);
        chk("wr_issue_cycle", ni, 2);
        chk("wr_latency", na + 1, 4);
        chk("wr_databus", b, 8'h41);
        chk("wr_ack", a, 2'b01);
        chk("wr_err", e, 1'b0);

        // Contention from reset: 0, 1, 0.
        do_reset(2);
        tbr = 1; req_rw = 2'b00; req_addr = 4'b0000; req_wdata = 16'hB2A1; req = 2'b11;
        wait_ack(a0);
        wait_ack(a1);
        wait_ack(a2);
        chk("rr_first", a0, 2'b01);
        chk("rr_second", a1, 2'b10);
        chk("rr_third", a2, 2'b01);
        cycle();
        req = 2'b00;

        // RX read waits for rda; ISSUE one cycle after rda rises.
        tbr = 0; rda = 0; tb_bus_val = 8'h5A;
        req_rw = 2'b10; req_addr = 4'b0000; req = 2'b10;
        run_txn(5, ni, na, b, a, e, r);
        chk("rx_issue_cycle", ni, 6);
        chk("rx_ack_cycle", na, 7);
        chk("rx_ack", a, 2'b10);
        chk("rx_rdata", r, 8'h5A);
        chk("rx_err", e, 1'b0);

        // Timeout: 8 waiting cycles, then err ack with no bus cycle.
        tbr = 0; rda = 0; req_rw = 2'b00; req_addr = 4'b0000; req_wdata = 16'h0077; req = 2'b01;
        run_txn(-1, ni, na, b, a, e, r);
        chk("to_no_issue", ni, 32'hFFFF_FFFF);
        chk("to_ack_cycle", na, 9);
        chk("to_ack", a, 2'b01);
        chk("to_err", e, 1'b1);
        chk("to_rdata_held", r, 8'h5A);

        // tbr rising on the last waiting cycle still issues normally.
        tbr = 0; rda = 0; req_wdata = 16'h0078; req = 2'b01;
        run_txn(8, ni, na, b, a, e, r);
        chk("late_issue_cycle", ni, 9);
        chk("late_ack_cycle", na, 10);
        chk("late_databus", b, 8'h78);
        chk("late_err", e, 1'b0);

        // Status read is ready immediately.
        tbr = 0; rda = 0; tb_bus_val = 8'hC3;
        req_rw = 2'b01; req_addr = 4'b0001; req = 2'b01;
        run_txn(-1, ni, na, b, a, e, r);
        chk("st_issue_cycle", ni, 2);
        chk("st_ack_cycle", na, 3);
        chk("st_rdata", r, 8'hC3);

        // Reset during WAIT_RDY.
        tbr = 0; req_rw = 2'b00; req_addr = 4'b0000; req = 2'b01;
        cycle(); cycle(); cycle();
        do_reset(2);

        // Reset during ISSUE after requester 0 was granted; then 0 must win again.
        tb_bus_val = 8'h99; req_rw = 2'b01; req_addr = 4'b0001; req = 2'b01;
        cycle(); cycle();
        chk("issue_before_rst", iocs, 1'b1);
        do_reset(2);
        tbr = 1; req_rw = 2'b00; req_addr = 4'b0000; req = 2'b11;
        wait_ack(a0);
        chk("post_rst_first", a0, 2'b01);
        cycle();
        req = 2'b00;

        // Randomized requesters, readiness and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            cycle();
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 2));
                continue;
            end
            rda = ($urandom_range(0, 2) == 0);
            tbr = ($urandom_range(0, 2) == 0);
            tb_bus_val = 8'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (m_ack_prev[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                    else rand_attr(i);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_attr(i);
                        req[i] = 1'b1;
                    end
                end else if (m_busy && int'(m_who) == i) begin
                    if ($urandom_range(0, 1) == 0) rand_attr(i);
                end
            end
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
